// File: rtl/fixed_softmax_normalizer.sv
// fixed_softmax_normalizer
// Last stage of the softmax datapath. Stores one vector's worth of exponentiated blocks,
// captures the vector's per-row exponent sum, then replays the blocks with every element
// divided by its row's sum.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   data_in_0*          exp blocks in (valid/ready); element index = row*P0 + col
//   sum_in_0*           per-row exponent sum in (valid/ready), one per vector
//   data_out_0*         normalised blocks out (valid/ready), registered
module fixed_softmax_normalizer #(
    parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1       = 4,
    parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int unsigned DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int unsigned IN_0_DEPTH =
        DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0,
    parameter int unsigned DATA_OUT_0_PRECISION_0      = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1      = 4,
    parameter int unsigned SUM_WIDTH =
        DATA_IN_0_PRECISION_0 + $clog2(DATA_IN_0_TENSOR_SIZE_DIM_0)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0
                                                  [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    input  logic [SUM_WIDTH-1:0]              sum_in_0 [DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              sum_in_0_valid,
    output logic                              sum_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0
                                                  [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int unsigned P0    = DATA_IN_0_PARALLELISM_DIM_0;
    localparam int unsigned P1    = DATA_IN_0_PARALLELISM_DIM_1;
    localparam int unsigned NE    = P0 * P1;
    localparam int unsigned IW    = DATA_IN_0_PRECISION_0;
    localparam int unsigned OW    = DATA_OUT_0_PRECISION_0;
    localparam int unsigned OFRAC = DATA_OUT_0_PRECISION_1;
    // Wide enough for the shifted numerator and the full sum without truncation.
    localparam int unsigned DIV_W = IW + OFRAC + SUM_WIDTH;
    localparam int unsigned PTR_W = (IN_0_DEPTH > 1) ? $clog2(IN_0_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(IN_0_DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(IN_0_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IN_0_DEPTH);
    localparam logic [DIV_W-1:0] OUT_MAX   = {{(DIV_W-OW){1'b0}}, {OW{1'b1}}};

    typedef enum logic [1:0] {StFill, StWaitSum, StDrain} state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   load_cnt_q;
    logic               sum_held_q;
    logic [SUM_WIDTH-1:0] sum_q [P1];
    logic [IW-1:0]      buf_q [IN_0_DEPTH][NE];
    logic [OW-1:0]      norm [NE];

    logic in_fire, sum_fire, out_fire, load;

    assign data_in_0_ready = (state_q == StFill);
    assign sum_in_0_ready  = !sum_held_q && (state_q != StDrain);
    assign in_fire         = data_in_0_valid && data_in_0_ready;
    assign sum_fire        = sum_in_0_valid && sum_in_0_ready;
    assign out_fire        = data_out_0_valid && data_out_0_ready;
    assign load            = (state_q == StDrain) && (!data_out_0_valid || data_out_0_ready)
                             && (load_cnt_q < DEPTH_CNT);

    // (e << OFRAC) / s, saturated to the output width; a zero sum saturates too.
    function automatic logic [OW-1:0] normalize(input logic [IW-1:0] e,
                                                input logic [SUM_WIDTH-1:0] s);
        logic [DIV_W-1:0] num;
        logic [DIV_W-1:0] den;
        logic [DIV_W-1:0] q;
        num = DIV_W'(e) << OFRAC;
        den = DIV_W'(s);
        if (s == '0) return '1;
        q = num / den;
        if (q > OUT_MAX) return '1;
        return q[OW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NE; i++) begin
            norm[i] = normalize(buf_q[rd_ptr_q][i], sum_q[i / P0]);
        end
    end

    // Block storage needs no reset: wr_ptr restarts at 0 so stale entries are overwritten.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[wr_ptr_q] <= data_in_0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StFill;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            load_cnt_q       <= '0;
            sum_held_q       <= 1'b0;
            sum_q            <= '{default: '0};
            data_out_0       <= '{default: '0};
            data_out_0_valid <= 1'b0;
        end else begin
            if (sum_fire) begin
                sum_q      <= sum_in_0;
                sum_held_q <= 1'b1;
            end
            unique case (state_q)
                StFill: begin
                    if (in_fire) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (wr_ptr_q == LAST_PTR) begin
                            state_q <= (sum_held_q || sum_fire) ? StDrain : StWaitSum;
                        end
                    end
                end
                StWaitSum: begin
                    if (sum_fire) state_q <= StDrain;
                end
                StDrain: begin
                    if (load) begin
                        data_out_0       <= norm;
                        data_out_0_valid <= 1'b1;
                        rd_ptr_q         <= rd_ptr_q + PTR_W'(1);
                        load_cnt_q       <= load_cnt_q + CNT_W'(1);
                    end else if (out_fire) begin
                        data_out_0_valid <= 1'b0;
                        // Only reachable with everything loaded: this was the final beat.
                        if (load_cnt_q == DEPTH_CNT) begin
                            state_q    <= StFill;
                            wr_ptr_q   <= '0;
                            rd_ptr_q   <= '0;
                            load_cnt_q <= '0;
                            sum_held_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_softmax_normalizer.sv
module tb_fixed_softmax_normalizer;

    logic        clk;
    logic        rst;
    logic [7:0]  din [1];
    logic        din_valid;
    logic        din_ready;
    logic [11:0] sin [1];
    logic        sin_valid;
    logic        sin_ready;
    logic [7:0]  dout [1];
    logic        dout_valid;
    logic        dout_ready;

    fixed_softmax_normalizer dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din),
        .data_in_0_valid  (din_valid),
        .data_in_0_ready  (din_ready),
        .sum_in_0         (sin),
        .sum_in_0_valid   (sin_valid),
        .sum_in_0_ready   (sin_ready),
        .data_out_0       (dout),
        .data_out_0_valid (dout_valid),
        .data_out_0_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_pop_cyc = -1;
    bit         rand_ready = 1'b0;
    bit         in_drain = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] vec [10];

    function automatic logic [7:0] model(input logic [7:0] e, input logic [11:0] s);
        int unsigned q;
        if (s == 12'd0) return 8'hFF;
        q = (int'(e) * 16) / int'(s);
        return (q > 255) ? 8'hFF : 8'(q);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: score this cycle's output, then advance one clock.
    task automatic tick();
        if (dout_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed %0h expected none", dout[0]);
            end
            if (exp_q.size() != 0) begin
                checks++;
                assert (dout[0] === exp_q[0]) else begin
                    errors++;
                    $error("FAIL out_data observed %0h expected %0h", dout[0], exp_q[0]);
                end
                if (dout_ready) begin
                    void'(exp_q.pop_front());
                    last_pop_cyc = cyc;
                end
            end
        end
        if (in_drain && exp_q.size() != 0) check("in_ready_low_drain", 32'(din_ready), 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic feed(input logic [7:0] e, output int acc_cyc);
        bit acc = 1'b0;
        din[0] = e;
        din_valid = 1'b1;
        acc_cyc = -1;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = din_ready;
            if (acc) acc_cyc = cyc;
            tick();
        end
        din_valid = 1'b0;
        check("feed_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_sum(input logic [11:0] s);
        bit acc = 1'b0;
        sin[0] = s;
        sin_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = sin_ready;
            tick();
        end
        sin_valid = 1'b0;
        check("sum_accept", 32'(acc), 32'd1);
    endtask

    task automatic expect_vec(input logic [11:0] s);
        for (int i = 0; i < 10; i++) exp_q.push_back(model(vec[i], s));
    endtask

    task automatic feed_vec();
        int c;
        for (int i = 0; i < 10; i++) feed(vec[i], c);
    endtask

    task automatic drain();
        in_drain = 1'b1;
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) tick();
        check("drain_done", 32'(exp_q.size()), 32'd0);
        check("in_ready_after", 32'(din_ready), 32'd1);
        check("valid_after", 32'(dout_valid), 32'd0);
        in_drain = 1'b0;
        exp_q.delete();
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_data", 32'(dout[0]), 32'd0);
        @(negedge clk);
        check("rst_in_ready", 32'(din_ready), 32'd1);
        check("rst_sum_ready", 32'(sin_ready), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        in_drain = 1'b0;
    endtask

    initial begin
        int c;
        rst = 1'b0;
        din[0] = '0;
        din_valid = 1'b0;
        sin[0] = '0;
        sin_valid = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_data", 32'(dout[0]), 32'd0);
        check("reset_in_ready", 32'(din_ready), 32'd1);
        check("reset_sum_ready", 32'(sin_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // 1.0 / 10.0 with the sum supplied first; check first-output latency.
        for (int i = 0; i < 10; i++) vec[i] = 8'h10;
        expect_vec(12'd160);
        send_sum(12'd160);
        feed_vec();
        check("latency_not_yet", 32'(dout_valid), 32'd0);
        in_drain = 1'b1;
        tick();
        check("latency_valid", 32'(dout_valid), 32'd1);
        drain();

        // Sum held back after all blocks: stays in WAIT_SUM with no output.
        for (int i = 0; i < 10; i++) vec[i] = 8'(16 * (i + 1));
        expect_vec(12'h010);
        feed_vec();
        in_drain = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_sum_no_valid", 32'(dout_valid), 32'd0);
            check("wait_sum_ready", 32'(sin_ready), 32'd1);
        end
        send_sum(12'h010);
        drain();

        // Saturation with sum 1 (0x10 is exactly one past max), then zero sum.
        vec = '{8'hFF, 8'h00, 8'h01, 8'h0F, 8'h10, 8'h08, 8'h02, 8'h80, 8'h0E, 8'hFF};
        expect_vec(12'd1);
        send_sum(12'd1);
        feed_vec();
        drain();
        vec = '{8'h00, 8'hFF, 8'h10, 8'h01, 8'h7F, 8'h20, 8'h00, 8'h05, 8'hAA, 8'h33};
        expect_vec(12'd0);
        feed_vec();
        send_sum(12'd0);
        drain();

        // Random backpressure; every valid cycle is scored against the queue head.
        for (int i = 0; i < 10; i++) vec[i] = 8'((i * 23 + 5) % 256);
        expect_vec(12'h030);
        send_sum(12'h030);
        rand_ready = 1'b1;
        feed_vec();
        drain();
        rand_ready = 1'b0;
        tick();

        // Back-to-back vectors: the next block lands the cycle after the last output.
        for (int i = 0; i < 10; i++) vec[i] = 8'(3 * i + 1);
        expect_vec(12'h020);
        send_sum(12'h020);
        feed_vec();
        in_drain = 1'b1;
        for (int i = 0; i < 10; i++) vec[i] = 8'(8'hF0 - 5 * i);
        expect_vec(12'h050);
        in_drain = 1'b0;
        feed(vec[0], c);
        check("b2b_accept_cycle", 32'(c), 32'(last_pop_cyc + 1));
        check("b2b_queue_left", 32'(exp_q.size()), 32'd10);
        for (int i = 1; i < 10; i++) feed(vec[i], c);
        send_sum(12'h050);
        drain();

        // Reset in the middle of a drain clears the output register immediately.
        for (int i = 0; i < 10; i++) vec[i] = 8'(8'h40 + i);
        expect_vec(12'h010);
        send_sum(12'h010);
        feed_vec();
        for (int i = 0; i < 4; i++) tick();
        pulse_reset();

        // Reset after 4 of 10 blocks; the held sum must be discarded as well.
        send_sum(12'h040);
        for (int i = 0; i < 4; i++) feed(8'hEE, c);
        pulse_reset();
        for (int i = 0; i < 10; i++) vec[i] = 8'(7 * i + 2);
        expect_vec(12'h020);
        feed_vec();
        send_sum(12'h020);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
